// File: rtl/seq_mul_rv_pkg.sv
// Shared definitions for the sequential RV M-extension multiplier.
// Opcode encodings, FSM states and operand signedness helpers.
package mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic rs1_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_signed(input logic [1:0] op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/seq_mul_rv_if.sv
// Request/response bundle between EX and the multiplier.
// master = pipeline side, slave = multiplier side.
interface seq_mul_rv_if #(
    parameter int XLEN = 32
);
    logic              start;
    logic              kill;
    logic [1:0]        op;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;
    logic [2*XLEN-1:0] product;

    modport master (
        output start, kill, op, rs1, rs2,
        input  busy, done, result, product
    );

    modport slave (
        input  start, kill, op, rs1, rs2,
        output busy, done, result, product
    );
endinterface

// File: rtl/seq_mul_rv_core.sv
// Unsigned XLEN x XLEN shift-add datapath, one multiplier bit per step.
// Multiplicand shifts left into a 2*XLEN accumulator, LSB of multiplier first.
module seq_mul_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic              step,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic [2*XLEN-1:0] acc,
    output logic [CNT_W-1:0]  cnt
);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   mp;

    // Load operands, then add-and-shift once per step
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc <= '0;
            sh  <= '0;
            mp  <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            sh  <= {{XLEN{1'b0}}, mcand};
            mp  <= mplier;
            cnt <= '0;
        end else if (step) begin
            if (mp[0]) begin
                acc <= acc + sh;
            end
            sh  <= sh << 1;
            mp  <= mp >> 1;
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seq_mul_rv.sv
// Multi-cycle MUL/MULH/MULHSU/MULHU unit beside the EX-stage ALU.
// Owns the FSM, sign conditioning of operands and result selection.
module seq_mul_rv
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic         Clk,
    input  logic         Rst,
    seq_mul_rv_if.slave  bus
);
    state_t            state, state_nx;
    logic              load, step;
    logic              neg;
    logic [1:0]        op_q;
    logic              s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] acc, prod_fix;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result;
    logic [2*XLEN-1:0] product;

    seq_mul_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .Clk    (Clk),
        .Rst    (Rst),
        .load   (load),
        .step   (step),
        .mcand  (mag1),
        .mplier (mag2),
        .acc    (acc),
        .cnt    (cnt)
    );

    // Magnitudes of the operands; most-negative value maps to 2^(XLEN-1)
    always_comb begin
        s1       = rs1_signed(bus.op) & bus.rs1[XLEN-1];
        s2       = rs2_signed(bus.op) & bus.rs2[XLEN-1];
        mag1     = s1 ? -bus.rs1 : bus.rs1;
        mag2     = s2 ? -bus.rs2 : bus.rs2;
        prod_fix = neg ? -acc : acc;
    end

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and core controls; kill always wins over start
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.start && !bus.kill) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.kill) begin
                    state_nx = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state_nx = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_nx = bus.kill ? S_IDLE : S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Latch sign/op at accept; publish product and result on the FIX edge
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            neg     <= 1'b0;
            op_q    <= OP_MUL;
            product <= '0;
            result  <= '0;
        end else begin
            if (load) begin
                neg  <= s1 ^ s2;
                op_q <= bus.op;
            end
            if (state == S_FIX && !bus.kill) begin
                product <= prod_fix;
                result  <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0]
                                            : prod_fix[2*XLEN-1:XLEN];
            end
        end
    end

    assign bus.busy    = (state == S_RUN) || (state == S_FIX);
    assign bus.done    = (state == S_DONE);
    assign bus.result  = result;
    assign bus.product = product;
endmodule

// File: tb/tb_seq_mul_rv.sv
// Self-checking bench for seq_mul_rv with a cycle-level behavioural model.
// Directed cases from the RV M-extension semantics plus randomized traffic.
module tb_seq_mul_rv;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    seq_mul_rv_if #(.XLEN(XLEN)) bus ();

    seq_mul_rv #(.XLEN(XLEN)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference product from plain signed/unsigned 64-bit arithmetic
    function automatic logic [63:0] ref_prod(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        sb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return 64'(sa * sb);
    endfunction

    // Model: an accepted request completes LAT edges later unless killed
    int          rem    = 0;
    logic        done_m = 1'b0;
    logic [63:0] prod_m = '0;
    logic [31:0] res_m  = '0;
    logic [63:0] pend_p = '0;
    logic [31:0] pend_r = '0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rem    = 0;
            done_m = 1'b0;
            prod_m = '0;
            res_m  = '0;
        end else if (rem > 0) begin
            done_m = 1'b0;
            if (bus.kill) begin
                rem = 0;
            end else begin
                rem--;
                if (rem == 0) begin
                    done_m = 1'b1;
                    prod_m = pend_p;
                    res_m  = pend_r;
                end
            end
        end else begin
            done_m = 1'b0;
            if (bus.start && !bus.kill) begin
                rem    = LAT;
                pend_p = ref_prod(bus.op, bus.rs1, bus.rs2);
                pend_r = (bus.op == 2'b00) ? pend_p[31:0] : pend_p[63:32];
            end
        end
    end

    // Compare outputs against the model every cycle
    always @(negedge Clk) begin
        chk("busy", 64'(bus.busy), 64'(rem > 0));
        chk("done", 64'(bus.done), 64'(done_m));
        chk("result", 64'(bus.result), 64'(res_m));
        chk("product", bus.product, prod_m);
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge Clk);
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
    endtask

    task automatic wait_done(input string name, input bit chk_lat);
        int n;
        n = 0;
        while (n < LAT + 8) begin
            @(posedge Clk);
            #1;
            n++;
            if (bus.done) break;
        end
        if (chk_lat) begin
            chk({name, "_latency"}, 64'(n), 64'(LAT));
        end else if (!bus.done) begin
            chk({name, "_timeout"}, 64'(bus.done), 64'(1));
        end
    endtask

    task automatic run(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(name, 1'b1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = 2'b00;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_product", bus.product, 64'(0));
        #1 Rst = 1'b1;

        run("mul", 2'b00, 32'd120, 32'd29);
        chk("mul_res", 64'(bus.result), 64'h0000_0D98);
        chk("mul_prod", bus.product, 64'h0000_0000_0000_0D98);

        run("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulh_m1_prod", bus.product, 64'h1);
        chk("mulh_m1_res", 64'(bus.result), 64'h0);

        run("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000);
        chk("mulh_min_res", 64'(bus.result), 64'h4000_0000);

        run("mulhsu", 2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        chk("mulhsu_prod", bus.product, 64'hFFFF_FFFE_0000_0002);
        chk("mulhsu_res", 64'(bus.result), 64'hFFFF_FFFE);

        run("mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu_prod", bus.product, 64'hFFFF_FFFE_0000_0001);
        chk("mulhu_res", 64'(bus.result), 64'hFFFF_FFFE);

        // start while busy is ignored
        issue(2'b00, 32'd7, 32'd6);
        repeat (9) @(negedge Clk);
        bus.start = 1'b1;
        bus.rs1   = 32'd84;
        bus.rs2   = 32'd30;
        @(negedge Clk);
        bus.start = 1'b0;
        wait_done("glitch", 1'b0);
        chk("glitch_res", 64'(bus.result), 64'h2A);

        // back-to-back start in the DONE cycle
        run("b2b", 2'b00, 32'd84, 32'd30);
        chk("b2b_res", 64'(bus.result), 64'h9D8);

        // kill mid-run: no done, result holds
        issue(2'b00, 32'd5, 32'd5);
        repeat (4) @(negedge Clk);
        bus.kill = 1'b1;
        @(posedge Clk);
        #1;
        chk("kill_busy", 64'(bus.busy), 64'(0));
        @(negedge Clk);
        bus.kill = 1'b0;
        repeat (LAT + 2) @(negedge Clk);
        chk("kill_res", 64'(bus.result), 64'h9D8);

        // kill together with start in idle: nothing accepted
        @(negedge Clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        chk("killstart_busy", 64'(bus.busy), 64'(0));

        // asynchronous reset mid-run
        issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (8) @(posedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_done", 64'(bus.done), 64'(0));
        chk("arst_result", 64'(bus.result), 64'(0));
        chk("arst_product", bus.product, 64'(0));
        @(posedge Clk);
        #2 Rst = 1'b1;

        run("post_rst", 2'b00, 32'd30, 32'd29);
        chk("post_rst_res", 64'(bus.result), 64'h366);

        // randomized traffic, with occasional ignored starts and kills
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          sel;
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            a   = (sel == 0) ? 32'h8000_0000 :
                  (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            sel = $urandom_range(0, 5);
            b   = (sel == 0) ? 32'h8000_0000 :
                  (sel == 1) ? 32'h0 : $urandom;
            if (i % 7 == 6) begin
                issue(op, a, b);
                repeat ($urandom_range(1, 30)) @(negedge Clk);
                bus.kill = 1'b1;
                @(negedge Clk);
                bus.kill = 1'b0;
                repeat (2) @(negedge Clk);
            end else if (i % 5 == 3) begin
                issue(op, a, b);
                repeat ($urandom_range(1, 25)) @(negedge Clk);
                bus.start = 1'b1;
                @(negedge Clk);
                bus.start = 1'b0;
                wait_done("rnd_glitch", 1'b0);
            end else begin
                run("rnd", op, a, b);
                if (i % 3 == 0) repeat ($urandom_range(0, 3)) @(negedge Clk);
            end
        end

        repeat (3) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
